// File: rtl/reg_file_bypass.sv
// rtl/reg_file_bypass.sv - 32 x 32-bit RV32 register file with write-through bypass
// x0 has no storage; reset and the single write port both act at the rising CLK edge.
module reg_file_bypass #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              WRITE_ENABLE,
   input  logic [ADDR_W-1:0] WRITE_ADDR,
   input  logic [DATA_W-1:0] WRITE_DATA,
   input  logic [ADDR_W-1:0] READ_ADDR1,
   input  logic [ADDR_W-1:0] READ_ADDR2,
   output logic [DATA_W-1:0] OUT1,
   output logic [DATA_W-1:0] OUT2
);

   localparam int NREGS = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [1:NREGS-1];
   logic [DATA_W-1:0] regs_d [1:NREGS-1];

   always_comb begin
      for (int i = 1; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
         if (RESET) begin
            regs_d[i] = '0;
         end else if (WRITE_ENABLE && (WRITE_ADDR == ADDR_W'(i))) begin
            regs_d[i] = WRITE_DATA;
         end
      end
   end

   always_ff @(posedge CLK) begin
      for (int i = 1; i < NREGS; i++) begin
         regs_q[i] <= regs_d[i];
      end
   end

   // Reset and x0 force zero; otherwise a matching enabled write wins over storage.
   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] val;
      val = '0;
      if (!RESET && (addr != '0)) begin
         if (WRITE_ENABLE && (WRITE_ADDR == addr)) begin
            val = WRITE_DATA;
         end else begin
            for (int i = 1; i < NREGS; i++) begin
               if (addr == ADDR_W'(i)) begin
                  val = regs_q[i];
               end
            end
         end
      end
      return val;
   endfunction

   always_comb begin
      OUT1 = read_port(READ_ADDR1);
      OUT2 = read_port(READ_ADDR2);
   end

endmodule

// File: tb/tb_reg_file_bypass.sv
// tb/tb_reg_file_bypass.sv - directed self-checking bench for reg_file_bypass
module tb_reg_file_bypass;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        WRITE_ENABLE;
   logic [4:0]  WRITE_ADDR;
   logic [31:0] WRITE_DATA;
   logic [4:0]  READ_ADDR1;
   logic [4:0]  READ_ADDR2;
   logic [31:0] OUT1;
   logic [31:0] OUT2;

   int checks = 0;
   int errors = 0;

   reg_file_bypass #(.DATA_W(32), .ADDR_W(5)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .WRITE_ENABLE (WRITE_ENABLE),
      .WRITE_ADDR   (WRITE_ADDR),
      .WRITE_DATA   (WRITE_DATA),
      .READ_ADDR1   (READ_ADDR1),
      .READ_ADDR2   (READ_ADDR2),
      .OUT1         (OUT1),
      .OUT2         (OUT2)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
      WRITE_ENABLE = 1'b1;
      WRITE_ADDR   = addr;
      WRITE_DATA   = data;
      tick();
      WRITE_ENABLE = 1'b0;
   endtask

   initial begin
      RESET        = 1'b1;
      WRITE_ENABLE = 1'b0;
      WRITE_ADDR   = 5'd0;
      WRITE_DATA   = 32'h0;
      READ_ADDR1   = 5'd5;
      READ_ADDR2   = 5'd6;
      tick();
      tick();
      check("reset_out1", OUT1, 32'h0);
      check("reset_out2", OUT2, 32'h0);

      // Reset clear with a coincident write that must be lost
      RESET = 1'b0;
      write_reg(5'd5, 32'hDEADBEEF);
      READ_ADDR1 = 5'd5;
      settle();
      check("pre_reset_x5", OUT1, 32'hDEADBEEF);
      RESET        = 1'b1;
      WRITE_ENABLE = 1'b1;
      WRITE_ADDR   = 5'd6;
      WRITE_DATA   = 32'h11;
      READ_ADDR1   = 5'd5;
      READ_ADDR2   = 5'd6;
      settle();
      check("in_reset_out1", OUT1, 32'h0);
      check("in_reset_out2", OUT2, 32'h0);
      tick();
      RESET        = 1'b0;
      WRITE_ENABLE = 1'b0;
      settle();
      check("post_reset_x5", OUT1, 32'h0);
      check("post_reset_x6", OUT2, 32'h0);

      // Basic write/read at both ends of the address range
      write_reg(5'd1, 32'h12345678);
      write_reg(5'd31, 32'hFFFFFFFF);
      READ_ADDR1 = 5'd1;
      READ_ADDR2 = 5'd31;
      settle();
      check("basic_x1", OUT1, 32'h12345678);
      check("basic_x31", OUT2, 32'hFFFFFFFF);

      // x0 hardwired to zero even with an enabled write to it
      WRITE_ENABLE = 1'b1;
      WRITE_ADDR   = 5'd0;
      WRITE_DATA   = 32'hAAAA5555;
      READ_ADDR1   = 5'd0;
      READ_ADDR2   = 5'd0;
      settle();
      check("x0_same_cycle_out1", OUT1, 32'h0);
      check("x0_same_cycle_out2", OUT2, 32'h0);
      tick();
      WRITE_ENABLE = 1'b0;
      settle();
      check("x0_next_out1", OUT1, 32'h0);
      check("x0_next_out2", OUT2, 32'h0);

      // Bypass on both ports
      write_reg(5'd7, 32'h1);
      READ_ADDR1 = 5'd7;
      READ_ADDR2 = 5'd7;
      settle();
      check("x7_initial", OUT1, 32'h1);
      WRITE_ENABLE = 1'b1;
      WRITE_ADDR   = 5'd7;
      WRITE_DATA   = 32'h99;
      settle();
      check("bypass_out1", OUT1, 32'h99);
      check("bypass_out2", OUT2, 32'h99);
      tick();
      WRITE_ENABLE = 1'b0;
      settle();
      check("stored_out1", OUT1, 32'h99);
      check("stored_out2", OUT2, 32'h99);

      // Bypass and write both gated by enable
      write_reg(5'd8, 32'h5);
      WRITE_ENABLE = 1'b0;
      WRITE_ADDR   = 5'd8;
      WRITE_DATA   = 32'h77;
      READ_ADDR1   = 5'd8;
      settle();
      check("gated_bypass", OUT1, 32'h5);
      tick();
      check("gated_write", OUT1, 32'h5);

      // Held write under freeze while rs2 toggles
      write_reg(5'd10, 32'h2);
      WRITE_ENABLE = 1'b1;
      WRITE_ADDR   = 5'd9;
      WRITE_DATA   = 32'h3C;
      for (int k = 0; k < 4; k++) begin
         READ_ADDR2 = (k % 2 == 0) ? 5'd9 : 5'd10;
         settle();
         check($sformatf("freeze_out2_%0d", k), OUT2, (k % 2 == 0) ? 32'h3C : 32'h2);
         tick();
      end
      WRITE_ENABLE = 1'b0;
      READ_ADDR1   = 5'd9;
      READ_ADDR2   = 5'd10;
      settle();
      check("freeze_final_x9", OUT1, 32'h3C);
      check("freeze_final_x10", OUT2, 32'h2);
      READ_ADDR1 = 5'd1;
      settle();
      check("x1_retained", OUT1, 32'h12345678);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_file_bypass.md
# reg_file_bypass

32 x 32-bit integer register file for the RV32 pipeline's ID stage. Supplies the two source operands that the ID/EX pipeline register latches as OUT1/OUT2. Accepts one write per cycle from the writeback stage. Provides write-through bypass, so an instruction in ID reads a value being written back in the same cycle without an extra stall.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width (2^ADDR_W registers)

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  reset, synchronous, active-high
- WRITE_ENABLE  input  1  writeback write strobe, from MEM/WB
- WRITE_ADDR  input  ADDR_W  destination register (rd), from MEM/WB
- WRITE_DATA  input  DATA_W  writeback value
- READ_ADDR1  input  ADDR_W  rs1 field of instruction in ID
- READ_ADDR2  input  ADDR_W  rs2 field of instruction in ID
- OUT1  output  DATA_W  rs1 operand, to ID/EX OUT1_IN
- OUT2  output  DATA_W  rs2 operand, to ID/EX OUT2_IN

## Operation
- Storage: registers x1..x31 are state. x0 has no storage and always reads 0.
- Write: at the rising CLK edge, if WRITE_ENABLE=1, RESET=0 and WRITE_ADDR!=0, then reg[WRITE_ADDR] <= WRITE_DATA.
  - A write to x0 is discarded.
  - WRITE_DATA is ignored when WRITE_ENABLE=0.
- Read: combinational. OUT1 and OUT2 are evaluated independently with the same rule. For OUTn with address An:
  - RESET=1: OUTn = 0.
  - else An=0: OUTn = 0.
  - else WRITE_ENABLE=1 and WRITE_ADDR=An: OUTn = WRITE_DATA (bypass).
  - else: OUTn = reg[An].
- Both ports may address the same register. Both then return identical values, including the bypass case.
- Reset: at a rising edge with RESET=1, x1..x31 are all cleared to 0 in that single edge. Any write presented in that cycle is discarded.
- The block has no stall input.
  - During a pipeline BUSYWAIT freeze, MEM/WB holds its outputs, so the same write repeats each cycle. This is idempotent.
  - ID/EX ignores OUT1/OUT2 while frozen.

## Timing
- Write latency: 1 edge. The value is stored at the edge that samples it.
- Through the bypass, the value is visible on OUT1/OUT2 in the same cycle it is presented, before that edge.
- Read latency: 0 cycles (combinational from READ_ADDRn, WRITE_*, RESET).
- Reset value of every output: OUT1=0 and OUT2=0 while RESET=1, independent of stored contents.
  - From the first post-reset cycle, all registers read 0 until written.
- Reset asserted mid-operation:
  - Outputs drop to 0 combinationally.
  - Contents clear at the next rising edge.
  - A write coincident with that edge is lost.
- Reset deasserted: the first write is accepted at the first edge with RESET=0.
- Write port and read ports may change every cycle. There are no handshake or ordering constraints.
- No intra-assignment delays in RTL. Gate delay is modelled by the surrounding pipeline registers.

## Test plan
- Reset clear:
  - Write 0xDEADBEEF to x5.
  - Assert RESET for 1 edge, with a write of 0x11 to x6 in the same cycle.
  - Read x5 and x6 -> both 0. OUT1=OUT2=0 while RESET=1.
- Basic write/read:
  - Write 0x12345678 to x1 and 0xFFFFFFFF to x31 on consecutive edges.
  - Read READ_ADDR1=1, READ_ADDR2=31 -> OUT1=0x12345678, OUT2=0xFFFFFFFF.
- x0 hardwired:
  - WRITE_ENABLE=1, WRITE_ADDR=0, WRITE_DATA=0xAAAA5555.
  - Read x0 on both ports in the same cycle and the next -> 0 both times.
- Bypass:
  - x7 holds 0x1. Present a write of 0x99 to x7 with READ_ADDR1=READ_ADDR2=7 -> OUT1=OUT2=0x99 before the edge.
  - After the edge, with WRITE_ENABLE=0 -> still 0x99.
- Bypass gated by enable:
  - x8 holds 0x5. WRITE_ADDR=8, WRITE_DATA=0x77, WRITE_ENABLE=0 -> OUT1=0x5, and x8 is unchanged after the edge.
- Held write under freeze:
  - Repeat the write of 0x3C to x9 for 4 consecutive edges while READ_ADDR2 toggles between 9 and 10 (x10=0x2).
  - OUT2 alternates 0x3C and 0x2. x9=0x3C at the end.
